serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller that sequences a single instance of the team's 1-bit full adder `add1bit` over WIDTH clock cycles to add or subtract two WIDTH-bit operands. It owns the operand shift registers, the carry register, the bit counter and a valid/ready handshake on both sides. It sits between an operand producer and a result consumer wherever area matters more than throughput.

---
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: sequences one add1bit cell over WIDTH cycles
// with valid/ready handshakes on the operand and result sides.

module add1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, sub_q;

  logic fa_b, fa_sum, fa_cout;
  logic accept, run_last;
  logic in_ready_d, out_valid_d, busy_d;

  assign accept   = (state_q == IDLE) && in_valid;
  assign run_last = (state_q == RUN) && (cnt_q == CNT_LAST);

  // Subtraction is a + ~b + ~borrow, so B is inverted at the cell input.
  assign fa_b = b_sh_q[0] ^ sub_q;

  add1bit u_add1bit (
    .a     (a_sh_q[0]),
    .b     (fa_b),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (run_last)  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs follow the state being entered, then registered
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    unique case (state_nxt)
      IDLE:    in_ready_d  = 1'b1;
      RUN:     busy_d      = 1'b1;
      HOLD: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Operand shifters, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= a;
      b_sh_q   <= b;
      res_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= op_sub ? ~c_in : c_in;
      sub_q    <= op_sub;
    end else if (state_q == RUN) begin
      a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
      res_sh_q <= {fa_sum, res_sh_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CNT_W'(1);
      carry_q  <= fa_cout;
    end
  end

  // Result registers update only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (run_last) begin
      sum   <= {fa_sum, res_sh_q[WIDTH-1:1]};
      c_out <= fa_cout;
      ovf   <= fa_cout ^ carry_q;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.

module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             c_in, op_sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out, ovf, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, optionally inject a rejected second request during RUN,
  // wait out a backpressure window, then release the result.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tci, input logic tsub,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input int hold, input bit junk);
    a = ta; b = tb; c_in = tci; op_sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    a = ~ta; b = ~tb; c_in = ~tci; op_sub = ~tsub;
    if (junk) in_valid = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      if (junk) check({tag, " in_ready during RUN"}, 32'(in_ready), 32'd0);
      if (i == 3) in_valid = 1'b0;
    end
    check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " c_out"}, 32'(c_out), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold result"}, {23'd0, ovf, c_out, sum}, {23'd0, eo, ec, es});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
    check({tag, " busy after release"}, 32'(busy), 32'd0);
    check({tag, " result kept in IDLE"}, 32'(sum), 32'(es));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; out_ready = ~out_ready;
      a = 8'hA5 ^ 8'(i); b = 8'h3C; c_in = ~c_in; op_sub = ~op_sub;
    end
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", {23'd0, ovf, c_out, sum}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    do_op("add 0F+01",    8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0, 1'b0);
    do_op("add FF+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    do_op("add 7F+00+1",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    do_op("sub 05-07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 5, 1'b0);
    do_op("busy reject",  8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1, 1'b1);
    do_op("sub 10-01-1",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 2, 1'b0);

    // Reset mid-RUN at cnt=3
    a = 8'h3A; b = 8'h21; c_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("midrun busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst result", {23'd0, ovf, c_out, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-rst idle", 32'(in_ready), 32'd1);
    do_op("post-rst add", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
